// File: rtl/sw_ctrl.sv
// Stopwatch run/pause/lap/clear sequencer.
// Two raw buttons are synchronised and debounced, and their debounced rising edges
// drive a Moore FSM that produces the count enable, a one-cycle clear and a lap hold.
module sw_ctrl #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_i,
  input  logic       btn_lr_i,
  output logic       en_o,
  output logic       clr_o,
  output logic       lap_hold_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StLap   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       sync_vld_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q;
  logic [1:0]       armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       press;

  state_e state_q, state_d;
  logic   en_q, clr_q, clr_d, lap_q;

  assign btn_raw = {btn_lr_i, btn_ss_i};

  // Two-flop synchronisers; sync_vld_q marks when sync2_q carries post-reset data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_vld_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Debounce: count while synced level differs from debounced level, flip on terminal count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A button only becomes armed once it has been seen released after reset, so a
    // button held through reset release never produces a press.
    armed_d = armed_q | ({2{sync_vld_q[1]}} & ~sync2_q & ~deb_q);
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      armed_q    <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      armed_q    <= armed_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  assign press = deb_q & ~deb_prev_q & armed_q;

  // Next-state logic; start/stop wins over lap/reset when both press in one cycle.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (press[0]) begin
          state_d = StRun;
        end else if (press[1]) begin
          clr_d = 1'b1;
        end
      end
      StRun: begin
        if (press[0]) begin
          state_d = StPause;
        end else if (press[1]) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (press[0]) begin
          state_d = StPause;
        end else if (press[1]) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (press[0]) begin
          state_d = StRun;
        end else if (press[1]) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, all updated from the next state so they move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      lap_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == StRun) || (state_d == StLap);
      lap_q   <= (state_d == StLap);
      clr_q   <= clr_d;
    end
  end

  assign en_o       = en_q;
  assign clr_o      = clr_q;
  assign lap_hold_o = lap_q;
  assign state_o    = state_q;

endmodule
